// File: rtl/pudi_sync_fsm.sv
// pudi_sync_fsm
//   Registered 8b/10b code-group classifier and receive synchronization state
//   machine for the PCS synchronization path. Each accepted code-group is
//   classified as comma (K28.5), data, other special or invalid. That class
//   drives the loss-of-sync / comma-detect / acquire-sync / sync-acquired
//   state machine, which uses parametrised acquisition and loss thresholds.
//
//   Code-group bit order: pudi[9:0] = {a,b,c,d,e,i,f,g,h,j}, so 'a' is the MSB.
//
// Ports
//   clk              clock, rising edge
//   reset            synchronous active-high reset
//   pudi_valid       qualifies pudi; when low, no state, counter or rx_even change
//   pudi             received code-group
//   err_clr          clears err_count (wins over an increment)
//   code_sync_status 1 while in any sync-acquired level
//   rx_even          parity of the last accepted code-group (1 = even)
//   cg_out           registered copy of the last accepted pudi
//   cg_out_valid     previous-cycle pudi_valid
//   cg_is_comma      cg_out is K28.5 (either disparity)
//   cg_is_data       cg_out is a valid data code-group
//   cg_invalid       cg_out is outside the valid set
//   err_count        saturating count of invalid code-groups received in sync
module pudi_sync_fsm #(
    parameter int unsigned CG_WIDTH        = 10,
    parameter int unsigned COMMA_THRESH    = 3,
    parameter int unsigned GOOD_CGS_THRESH = 3,
    parameter int unsigned BAD_LIMIT       = 4,
    parameter int unsigned ERR_WIDTH       = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pudi_valid,
    input  logic [CG_WIDTH-1:0]  pudi,
    input  logic                 err_clr,
    output logic                 code_sync_status,
    output logic                 rx_even,
    output logic [CG_WIDTH-1:0]  cg_out,
    output logic                 cg_out_valid,
    output logic                 cg_is_comma,
    output logic                 cg_is_data,
    output logic                 cg_invalid,
    output logic [ERR_WIDTH-1:0] err_count
);

    localparam logic [1:0] StLos      = 2'd0;
    localparam logic [1:0] StCommaDet = 2'd1;
    localparam logic [1:0] StAcqSync  = 2'd2;
    localparam logic [1:0] StSyncAcq  = 2'd3;

    // good_cnt only ever holds 0..GOOD_CGS_THRESH-1; it clears on reaching the threshold.
    localparam int unsigned GoodW = (GOOD_CGS_THRESH > 1) ? $clog2(GOOD_CGS_THRESH) : 1;

    localparam logic [2:0]       CommaThr  = 3'(COMMA_THRESH);
    localparam logic [2:0]       BadMax    = 3'(BAD_LIMIT - 1);
    localparam logic [GoodW-1:0] GoodThrM1 = GoodW'(GOOD_CGS_THRESH - 1);
    localparam logic [ERR_WIDTH-1:0] ErrOne = {{(ERR_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]           state_q, state_d;
    logic [2:0]           comma_cnt_q, comma_cnt_d;
    logic [2:0]           bad_lvl_q, bad_lvl_d;
    logic [GoodW-1:0]     good_cnt_q, good_cnt_d;
    logic                 rx_even_q, rx_even_d;
    logic [CG_WIDTH-1:0]  cg_q;
    logic                 cg_valid_q;
    logic                 comma_q, data_q, invalid_q;
    logic [ERR_WIDTH-1:0] err_q;

    logic in_comma, in_data, in_special, in_invalid;
    logic cgbad;

    // Classification of the incoming code-group, both running disparities.
    always_comb begin
        in_comma   = 1'b0;
        in_data    = 1'b0;
        in_special = 1'b0;
        case (pudi)
            10'b001111_1010, 10'b110000_0101: in_comma = 1'b1; // K28.5
            10'b111010_1000, 10'b000101_0111,                  // K23.7
            10'b110110_1000, 10'b001001_0111,                  // K27.7
            10'b101110_1000, 10'b010001_0111: in_special = 1'b1; // K29.7
            10'b101001_0110,                                   // D5.6
            10'b011011_0101, 10'b100100_0101,                  // D16.2
            10'b100111_0100, 10'b011000_1011,                  // D0.0
            10'b011101_0100, 10'b100010_1011,                  // D1.0
            10'b101101_0100, 10'b010010_1011,                  // D2.0
            10'b101101_0101, 10'b010010_0101,                  // D2.2
            10'b101010_1010,                                   // D21.5
            10'b110100_1100, 10'b110100_0011,                  // D11.3
            10'b111010_1001, 10'b000101_1001,                  // D23.1
            10'b111000_1101, 10'b000111_0010,                  // D7.4
            10'b001101_1010,                                   // D12.5
            10'b001110_1010,                                   // D28.5
            10'b110001_0110,                                   // D3.6
            10'b111001_0110, 10'b000110_0110,                  // D8.6
            10'b110010_0101,                                   // D19.2
            10'b110011_0011, 10'b001100_1100,                  // D24.3
            10'b101011_1001, 10'b010100_1001,                  // D31.1
            10'b010101_1001,                                   // D10.1
            10'b101110_0011, 10'b010001_1100,                  // D29.3
            10'b110101_0110, 10'b001010_0110: in_data = 1'b1;  // D4.6
            default: ;
        endcase
        in_invalid = ~(in_comma | in_data | in_special);
    end

    // A comma landing on an even position is misaligned and counts as bad.
    assign cgbad = in_invalid | (in_comma & rx_even_q);

    always_comb begin
        state_d     = state_q;
        comma_cnt_d = comma_cnt_q;
        bad_lvl_d   = bad_lvl_q;
        good_cnt_d  = good_cnt_q;
        rx_even_d   = rx_even_q;
        if (pudi_valid) begin
            rx_even_d = ~rx_even_q;
            case (state_q)
                StLos: begin
                    if (in_comma) begin
                        state_d     = StCommaDet;
                        comma_cnt_d = comma_cnt_q + 3'd1;
                        rx_even_d   = 1'b1;
                    end
                end
                StCommaDet: begin
                    if (in_data) begin
                        if (comma_cnt_q == CommaThr) begin
                            state_d    = StSyncAcq;
                            bad_lvl_d  = 3'd0;
                            good_cnt_d = '0;
                        end else begin
                            state_d = StAcqSync;
                        end
                    end else begin
                        state_d     = StLos;
                        comma_cnt_d = 3'd0;
                    end
                end
                StAcqSync: begin
                    if (in_comma && !rx_even_q) begin
                        state_d     = StCommaDet;
                        comma_cnt_d = comma_cnt_q + 3'd1;
                        rx_even_d   = 1'b1;
                    end else if (cgbad) begin
                        state_d     = StLos;
                        comma_cnt_d = 3'd0;
                    end
                end
                default: begin // StSyncAcq
                    if (cgbad) begin
                        good_cnt_d = '0;
                        if (bad_lvl_q == BadMax) begin
                            state_d     = StLos;
                            comma_cnt_d = 3'd0;
                            bad_lvl_d   = 3'd0;
                        end else begin
                            bad_lvl_d = bad_lvl_q + 3'd1;
                        end
                    end else if (bad_lvl_q != 3'd0) begin
                        if (good_cnt_q == GoodThrM1) begin
                            bad_lvl_d  = bad_lvl_q - 3'd1;
                            good_cnt_d = '0;
                        end else begin
                            good_cnt_d = good_cnt_q + GoodW'(1);
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StLos;
            comma_cnt_q <= 3'd0;
            bad_lvl_q   <= 3'd0;
            good_cnt_q  <= '0;
            rx_even_q   <= 1'b0;
            cg_q        <= '0;
            cg_valid_q  <= 1'b0;
            comma_q     <= 1'b0;
            data_q      <= 1'b0;
            invalid_q   <= 1'b0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            comma_cnt_q <= comma_cnt_d;
            bad_lvl_q   <= bad_lvl_d;
            good_cnt_q  <= good_cnt_d;
            rx_even_q   <= rx_even_d;
            cg_valid_q  <= pudi_valid;
            if (pudi_valid) begin
                cg_q      <= pudi;
                comma_q   <= in_comma;
                data_q    <= in_data;
                invalid_q <= in_invalid;
            end
            if (err_clr) begin
                err_q <= '0;
            end else if (pudi_valid && in_invalid && (state_q == StSyncAcq) && (err_q != '1)) begin
                err_q <= err_q + ErrOne;
            end
        end
    end

    assign code_sync_status = (state_q == StSyncAcq);
    assign rx_even          = rx_even_q;
    assign cg_out           = cg_q;
    assign cg_out_valid     = cg_valid_q;
    assign cg_is_comma      = comma_q;
    assign cg_is_data       = data_q;
    assign cg_invalid       = invalid_q;
    assign err_count        = err_q;

endmodule
